// File: rtl/stereo_sample_fifo_pkg.sv
// Shared definitions for the stereo sample FIFO and the audio_mux that drains it:
// default geometry and the PRIME/RUN state encoding.
package stereo_sample_fifo_pkg;

  localparam int SSF_FIFO_WIDTH    = 6;
  localparam int SSF_AUD_BIT_DEPTH = 24;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } ssf_state_e;

endpackage

// File: rtl/stereo_sample_fifo_ram.sv
// Stereo pair storage: synchronous write, asynchronous (show-ahead) read.
// Contents are never reset.
module stereo_fifo_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/stereo_sample_fifo.sv
// Prefilling stereo sample FIFO between the synth voice output and audio_mux.
// Holds silence until the prefill level is reached, then streams pairs on r_read.
module stereo_sample_fifo
  import stereo_sample_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH    = SSF_FIFO_WIDTH,
  parameter int AUD_BIT_DEPTH = SSF_AUD_BIT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [AUD_BIT_DEPTH-1:0] lsound_wr,
  input  logic [AUD_BIT_DEPTH-1:0] rsound_wr,
  input  logic                     l_read,
  input  logic                     r_read,
  input  logic [FIFO_WIDTH:0]      threshold,
  input  logic                     flush,
  input  logic                     clear_flags,
  output logic [AUD_BIT_DEPTH-1:0] lsound_out,
  output logic [AUD_BIT_DEPTH-1:0] rsound_out,
  output logic [FIFO_WIDTH:0]      level,
  output logic                     full,
  output logic                     empty,
  output logic                     fill_req,
  output logic                     running,
  output logic                     overflow,
  output logic                     underflow
);

  localparam logic [FIFO_WIDTH:0]   LVL_ONE  = {{FIFO_WIDTH{1'b0}}, 1'b1};
  localparam logic [FIFO_WIDTH:0]   LVL_FULL = {1'b1, {FIFO_WIDTH{1'b0}}};
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE  = {{(FIFO_WIDTH-1){1'b0}}, 1'b1};

  ssf_state_e                state_q, state_d;
  logic [FIFO_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FIFO_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH:0]       level_q, level_d;
  logic                      overflow_q, overflow_d;
  logic                      underflow_q, underflow_d;
  logic                      push_ok, pop_ok;
  logic                      full_w, empty_w;
  logic [FIFO_WIDTH:0]       thr_eff;
  logic [2*AUD_BIT_DEPTH-1:0] rd_pair;
  logic                      show_w;

  // The left strobe is only a timing hint from audio_mux; it never moves the FIFO.
  logic unused_l_read;
  assign unused_l_read = l_read;

  assign full_w  = (level_q == LVL_FULL);
  assign empty_w = (level_q == '0);
  // A zero threshold would otherwise let PRIME exit with nothing to play.
  assign thr_eff = (threshold == '0) ? LVL_ONE : threshold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PRIME;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_ok     = 1'b0;
    pop_ok      = 1'b0;

    // Clear first so that a same-cycle error event below wins.
    if (clear_flags) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    if (flush) begin
      state_d  = PRIME;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      pop_ok  = r_read && (state_q == RUN) && !empty_w;
      push_ok = wr_en && (!full_w || pop_ok);

      if (wr_en && !push_ok) overflow_d = 1'b1;

      if (r_read && (state_q == RUN) && empty_w) begin
        underflow_d = 1'b1;
        state_d     = PRIME;
      end else if ((state_q == PRIME) && (level_q >= thr_eff)) begin
        state_d = RUN;
      end

      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok && !pop_ok)      level_d = level_q + LVL_ONE;
      else if (pop_ok && !push_ok) level_d = level_q - LVL_ONE;
    end
  end

  stereo_fifo_ram #(
    .ADDR_W (FIFO_WIDTH),
    .DATA_W (2*AUD_BIT_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push_ok && !reset),
    .waddr_i (wr_ptr_q),
    .wdata_i ({lsound_wr, rsound_wr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_pair)
  );

  // Stale RAM contents must never reach the DAC: silence outside RUN or when empty.
  assign show_w     = (state_q == RUN) && !empty_w;
  assign lsound_out = show_w ? rd_pair[2*AUD_BIT_DEPTH-1:AUD_BIT_DEPTH] : '0;
  assign rsound_out = show_w ? rd_pair[AUD_BIT_DEPTH-1:0] : '0;

  assign level     = level_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign fill_req  = (level_q < threshold);
  assign running   = (state_q == RUN);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_stereo_sample_fifo.sv
// Self-checking bench for stereo_sample_fifo: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_stereo_sample_fifo;

  localparam int FW    = 6;
  localparam int AW    = 24;
  localparam int DEPTH = 64;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] lsound_wr, rsound_wr;
  logic          l_read, r_read;
  logic [FW:0]   threshold;
  logic          flush, clear_flags;
  logic [AW-1:0] lsound_out, rsound_out;
  logic [FW:0]   level;
  logic          full, empty, fill_req, running, overflow, underflow;

  int n_pass;
  int n_total;

  stereo_sample_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .lsound_wr   (lsound_wr),
    .rsound_wr   (rsound_wr),
    .l_read      (l_read),
    .r_read      (r_read),
    .threshold   (threshold),
    .flush       (flush),
    .clear_flags (clear_flags),
    .lsound_out  (lsound_out),
    .rsound_out  (rsound_out),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .fill_req    (fill_req),
    .running     (running),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of queued pairs, a playing flag and two sticky flags.
  logic [2*AW-1:0] mq[$];
  bit m_run, m_ovf, m_unf;

  task automatic model_step();
    int sz, tgt;
    bit pop, push, uevt;
    if (reset) begin
      mq.delete(); m_run = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    if (clear_flags) begin m_ovf = 0; m_unf = 0; end
    if (flush) begin
      mq.delete(); m_run = 0;
      return;
    end
    sz   = mq.size();
    tgt  = (threshold == 0) ? 1 : int'(threshold);
    pop  = r_read && m_run && (sz > 0);
    uevt = r_read && m_run && (sz == 0);
    push = wr_en && ((sz < DEPTH) || pop);
    if (wr_en && !push) m_ovf = 1;
    if (uevt) begin m_unf = 1; m_run = 0; end
    else if (!m_run && sz >= tgt) m_run = 1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({lsound_wr, rsound_wr});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    int sz;
    logic [AW-1:0] el, er;
    sz = mq.size();
    el = '0; er = '0;
    if (m_run && sz > 0) begin
      el = mq[0][2*AW-1:AW];
      er = mq[0][AW-1:0];
    end
    chk({tag, ".level"},     32'(level),     32'(sz));
    chk({tag, ".full"},      32'(full),      32'(sz == DEPTH));
    chk({tag, ".empty"},     32'(empty),     32'(sz == 0));
    chk({tag, ".fill_req"},  32'(fill_req),  32'(sz < int'(threshold)));
    chk({tag, ".running"},   32'(running),   32'(m_run));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    chk({tag, ".lsound"},    32'(lsound_out), 32'(el));
    chk({tag, ".rsound"},    32'(rsound_out), 32'(er));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    wr_en = 0; r_read = 0; l_read = 0; flush = 0; clear_flags = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic push(input logic [AW-1:0] l, input logic [AW-1:0] r);
    idle();
    wr_en = 1; lsound_wr = l; rsound_wr = r;
    step();
    wr_en = 0;
  endtask

  typedef struct {
    bit            wr;
    bit            rd;
    bit            lr;
    bit            clr;
    logic [AW-1:0] l;
    logic [AW-1:0] r;
    int            exp_level;
    bit            exp_run;
    bit            exp_fill;
    bit            exp_unf;
    logic [AW-1:0] exp_l;
    logic [AW-1:0] exp_r;
  } vec_t;

  function automatic vec_t mkv(bit wr, bit rd, bit lr, bit clr, int k,
                               int lvl, bit run, bit fill, bit unf, int ek);
    vec_t v;
    v.wr = wr; v.rd = rd; v.lr = lr; v.clr = clr;
    v.l = 24'hA00000 + 24'(k);
    v.r = 24'h500000 + 24'(k);
    v.exp_level = lvl; v.exp_run = run; v.exp_fill = fill; v.exp_unf = unf;
    v.exp_l = (ek == 0) ? 24'h0 : 24'hA00000 + 24'(ek);
    v.exp_r = (ek == 0) ? 24'h0 : 24'h500000 + 24'(ek);
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    int thr_tab[7];
    logic [AW-1:0] wl, wr;
    n_pass = 0; n_total = 0;
    lsound_wr = '0; rsound_wr = '0; threshold = 7'd4;
    thr_tab = '{0, 1, 3, 8, 32, 64, 65};

    //          wr rd lr clr k   lvl run fill unf ek
    vecs[0]  = mkv(1, 0, 0, 0, 1,  1, 0, 1, 0, 0);
    vecs[1]  = mkv(1, 0, 0, 0, 2,  2, 0, 1, 0, 0);
    vecs[2]  = mkv(1, 0, 0, 0, 3,  3, 0, 1, 0, 0);
    vecs[3]  = mkv(1, 0, 0, 0, 4,  4, 0, 0, 0, 0);
    vecs[4]  = mkv(0, 0, 0, 0, 0,  4, 1, 0, 0, 1);
    vecs[5]  = mkv(0, 0, 1, 0, 0,  4, 1, 0, 0, 1);
    vecs[6]  = mkv(0, 1, 0, 0, 0,  3, 1, 1, 0, 2);
    vecs[7]  = mkv(0, 1, 0, 0, 0,  2, 1, 1, 0, 3);
    vecs[8]  = mkv(0, 0, 1, 0, 0,  2, 1, 1, 0, 3);
    vecs[9]  = mkv(0, 1, 0, 0, 0,  1, 1, 1, 0, 4);
    vecs[10] = mkv(0, 1, 0, 0, 0,  0, 1, 1, 0, 0);
    vecs[11] = mkv(0, 1, 0, 0, 0,  0, 0, 1, 1, 0);
    vecs[12] = mkv(0, 0, 0, 1, 0,  0, 0, 1, 0, 0);
    vecs[13] = mkv(0, 1, 0, 0, 0,  0, 0, 1, 0, 0);

    idle();
    reset = 1;
    step();
    step();
    chk("rst.level",     32'(level),      32'd0);
    chk("rst.empty",     32'(empty),      32'd1);
    chk("rst.full",      32'(full),       32'd0);
    chk("rst.running",   32'(running),    32'd0);
    chk("rst.overflow",  32'(overflow),   32'd0);
    chk("rst.underflow", 32'(underflow),  32'd0);
    chk("rst.lsound",    32'(lsound_out), 32'd0);
    chk("rst.rsound",    32'(rsound_out), 32'd0);
    reset = 0;

    // Prefill to threshold 4, then drain through an underflow.
    for (int i = 0; i < 14; i++) begin
      idle();
      wr_en = vecs[i].wr; r_read = vecs[i].rd; l_read = vecs[i].lr;
      clear_flags = vecs[i].clr;
      lsound_wr = vecs[i].l; rsound_wr = vecs[i].r;
      step();
      chk($sformatf("vec%0d.level", i),     32'(level),      32'(vecs[i].exp_level));
      chk($sformatf("vec%0d.running", i),   32'(running),    32'(vecs[i].exp_run));
      chk($sformatf("vec%0d.fill_req", i),  32'(fill_req),   32'(vecs[i].exp_fill));
      chk($sformatf("vec%0d.underflow", i), 32'(underflow),  32'(vecs[i].exp_unf));
      chk($sformatf("vec%0d.lsound", i),    32'(lsound_out), 32'(vecs[i].exp_l));
      chk($sformatf("vec%0d.rsound", i),    32'(rsound_out), 32'(vecs[i].exp_r));
    end
    idle();

    // Full FIFO, threshold above depth, overflow and push+pop while full.
    do_reset();
    threshold = 7'd65;
    for (int k = 0; k < DEPTH; k++) push(24'h001000 + 24'(k), 24'h002000 + 24'(k));
    chk("full.full",     32'(full),     32'd1);
    chk("full.level",    32'(level),    32'd64);
    chk("full.fill_req", 32'(fill_req), 32'd1);
    step();
    chk("full.held_prime", 32'(running), 32'd0);
    threshold = 7'd64;
    step();
    chk("full.running", 32'(running),    32'd1);
    chk("full.head",    32'(lsound_out), 32'h001000);
    push(24'h777777, 24'h888888);
    chk("ovf.flag",  32'(overflow), 32'd1);
    chk("ovf.level", 32'(level),    32'd64);
    wr_en = 1; r_read = 1; lsound_wr = 24'hABCDEF; rsound_wr = 24'h123456;
    step();
    idle();
    chk("pushpop.level", 32'(level),      32'd64);
    chk("pushpop.head",  32'(lsound_out), 32'h001001);
    wr_en = 1; clear_flags = 1; lsound_wr = 24'h999999;
    step();
    idle();
    chk("ovf.set_wins", 32'(overflow), 32'd1);
    clear_flags = 1;
    step();
    idle();
    chk("ovf.cleared", 32'(overflow), 32'd0);
    r_read = 1;
    for (int i = 0; i < 63; i++) begin
      step();
      check_model("drain");
    end
    chk("pushpop.tail_l", 32'(lsound_out), 32'hABCDEF);
    chk("pushpop.tail_r", 32'(rsound_out), 32'h123456);
    step();
    idle();
    check_model("drained");

    // Flush with traffic, then reset with traffic; next push lands at address 0.
    do_reset();
    threshold = 7'd4;
    for (int k = 0; k < 10; k++) push(24'h030000 + 24'(k), 24'h040000 + 24'(k));
    chk("flush.pre_level", 32'(level), 32'd10);
    flush = 1; wr_en = 1; r_read = 1; lsound_wr = 24'hDEAD00; rsound_wr = 24'hBEEF00;
    step();
    idle();
    chk("flush.level",   32'(level),      32'd0);
    chk("flush.running", 32'(running),    32'd0);
    chk("flush.empty",   32'(empty),      32'd1);
    chk("flush.lsound",  32'(lsound_out), 32'd0);
    threshold = 7'd1;
    push(24'h0F0F0F, 24'hF0F0F0);
    chk("flush.addr0", 32'(dut.u_ram.mem[0][2*AW-1:AW]), 32'h0F0F0F);
    step();
    chk("flush.head", 32'(lsound_out), 32'h0F0F0F);
    for (int k = 0; k < 9; k++) push(24'h050000 + 24'(k), 24'h060000 + 24'(k));
    chk("rstmid.pre_level", 32'(level), 32'd10);
    reset = 1; wr_en = 1; lsound_wr = 24'h5A5A5A; rsound_wr = 24'hA5A5A5;
    step();
    reset = 0;
    idle();
    chk("rstmid.level",   32'(level),   32'd0);
    chk("rstmid.running", 32'(running), 32'd0);
    push(24'h3C3C3C, 24'hC3C3C3);
    chk("rstmid.addr0", 32'(dut.u_ram.mem[0][2*AW-1:AW]), 32'h3C3C3C);

    // 100 pushes while draining continuously: pointers wrap.
    do_reset();
    threshold = 7'd2;
    for (int k = 0; k < 100; k++) begin
      wr_en = 1; r_read = 1;
      lsound_wr = 24'h700000 + 24'(k); rsound_wr = 24'h800000 + 24'(k);
      step();
      check_model("wrap");
    end
    wr_en = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_model("wrap_tail");
    end
    idle();

    // Randomized traffic.
    do_reset();
    threshold = 7'd4;
    for (int i = 0; i < 2000; i++) begin
      wr_en       = ($urandom_range(0, 99) < 55);
      r_read      = ($urandom_range(0, 99) < 50);
      l_read      = ($urandom_range(0, 99) < 50);
      flush       = ($urandom_range(0, 199) == 0);
      clear_flags = ($urandom_range(0, 49) == 0);
      lsound_wr   = 24'($urandom);
      rsound_wr   = 24'($urandom);
      if ($urandom_range(0, 99) == 0) threshold = 7'(thr_tab[$urandom_range(0, 6)]);
      step();
      check_model("rand");
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stereo_sample_fifo.md
STEREO_SAMPLE_FIFO -- requirements
Module: stereo_sample_fifo

Interface
REQ-001 Parameter FIFO_WIDTH, default 6; depth = 2**FIFO_WIDTH stereo entries.
REQ-002 Parameter AUD_BIT_DEPTH, default 24; width of each channel sample.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wr_en  in  1  push strobe from the synth voice output, one stereo pair per pulse.
REQ-006 lsound_wr, rsound_wr  in  AUD_BIT_DEPTH each  left/right sample pushed on wr_en.
REQ-007 l_read  in  1  left-channel read strobe from audio_mux; no pop.
REQ-008 r_read  in  1  right-channel read strobe from audio_mux; pops the head pair.
REQ-009 threshold  in  FIFO_WIDTH+1  prefill level, same value as the audio_mux buffersize register.
REQ-010 flush  in  1  synchronous empty-and-reprime request.
REQ-011 clear_flags  in  1  clears sticky overflow/underflow.
REQ-012 lsound_out, rsound_out  out  AUD_BIT_DEPTH each  head pair, wired to audio_mux lsound_in/rsound_in.
REQ-013 level  out  FIFO_WIDTH+1  current occupancy, 0..2**FIFO_WIDTH.
REQ-014 full, empty  out  1 each  level==depth / level==0.
REQ-015 fill_req  out  1  high while level < threshold; requests more samples from the synth.
REQ-016 running  out  1  high in RUN state.
REQ-017 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-018 Push: wr_en && !full writes pair at wr_ptr, wr_ptr+1 mod depth; wr_en && full drops data and sets overflow.
REQ-019 Pop: r_read in RUN && !empty advances rd_ptr mod depth; l_read never changes state.
REQ-020 Simultaneous accepted push and pop: level unchanged; when full, push is accepted together with the pop.
REQ-021 Simultaneous push and r_read when empty: push accepted; pop treated as underflow.
REQ-022 Outputs are show-ahead: lsound_out/rsound_out present memory[rd_ptr] combinationally; the new head is visible the cycle after a pop.
REQ-023 lsound_out/rsound_out are forced to 0 (silence) in PRIME state or when empty.
REQ-024 States: PRIME (reset/flush state), RUN.
REQ-025 PRIME->RUN when level >= max(threshold,1); r_read in PRIME pops nothing and sets no flag.
REQ-026 RUN->PRIME on r_read while empty; underflow is set in the same cycle.
REQ-027 RUN->PRIME on flush; flush also zeroes rd_ptr, wr_ptr and level, and overrides a simultaneous wr_en or r_read.
REQ-028 level is one bit wider than the pointers; full/empty derive from level, never from pointer equality alone.
REQ-029 fill_req compares unsigned; threshold > depth leaves fill_req high when full and holds PRIME until threshold is lowered.
REQ-030 clear_flags clears overflow/underflow; a same-cycle set event wins over clear.

Reset
REQ-031 On reset: state PRIME, pointers 0, level 0, empty 1, full 0, overflow 0, underflow 0, running 0, outputs 0; memory contents undefined and never observable.
REQ-032 Reset mid-operation discards all queued samples; the first post-reset push lands at address 0.

Structure
REQ-033 A shared package holds the state encoding (PRIME, RUN) and the FIFO_WIDTH/AUD_BIT_DEPTH defaults used by both this block and audio_mux.
REQ-034 One sub-module, stereo_fifo_ram: 2*AUD_BIT_DEPTH wide, depth 2**FIFO_WIDTH, synchronous write, asynchronous read.

Verification
REQ-035 threshold=4; push 3 pairs -> running=0, fill_req=1, outputs 0; 4th push -> running=1 next cycle, lsound_out = first left sample.
REQ-036 RUN with level=2; l_read then r_read twice -> level 0, pairs emitted in order; a third r_read -> underflow=1, state PRIME, outputs 0.
REQ-037 Fill 64 pairs (FIFO_WIDTH=6) -> full=1, level=64; extra wr_en -> overflow=1, level stays 64; push+r_read in the same cycle -> level 64, both accepted.
REQ-038 Push 100 pairs while draining continuously -> pointers wrap with no data loss or reordering, level never exceeds 64.
REQ-039 flush, or reset, asserted with level=10 and wr_en high -> level 0, PRIME, next push stored at address 0; clear_flags together with overflow -> overflow stays 1.
